input_conditioner: RTL and testbench
====================================

# input_conditioner

Front-end stage between the board's push-buttons/switches and the ALU. It synchronises the raw switch and button pads and debounces each button independently. Each debounced press becomes a single-cycle, strictly one-hot enable pulse. With each pulse it presents a stable switch snapshot, so the ALU's `i_enable==1/2/4` load decoding sees exactly one clean event per physical press.

## Interface
- `CANT_SWITCHES`, 4, width of switch bus in and out
- `CANT_BOTONES`, 4, number of buttons; width of enable bus in and out
- `DEBOUNCE_CYCLES`, 1000000, clock cycles a button must stay stable to be accepted (10 ms at 100 MHz); legal range ≥ 2
- `CLK100MHZ`  in  1  system clock, the only clock
- `i_reset`  in  1  reset; asynchronous assertion, active-low (0 = reset)
- `i_switch`  in  CANT_SWITCHES  raw switch pads, asynchronous
- `i_boton`  in  CANT_BOTONES  raw button pads, asynchronous, 1 = pressed
- `o_enable`  out  CANT_BOTONES  one-hot, one-cycle press pulse; drives ALU `i_enable`
- `o_switch`  out  CANT_SWITCHES  switch snapshot taken with the last pulse; drives ALU `i_switch`

## Operation
- **Synchronisation**
  - Every `i_switch` and `i_boton` bit passes through a 2-flop synchroniser; `s` denotes a synchronised button bit.
  - Switches are not debounced.
- **Per-button FSM** (4 states) with its own counter, width `$clog2(DEBOUNCE_CYCLES)`:
  - `IDLE`: if `s=1` → `PRESS_WAIT`, cnt←0.
  - `PRESS_WAIT`:
    - if `s=0` → `IDLE`;
    - else if cnt==`DEBOUNCE_CYCLES`-1 → `PRESSED` and set `pending[i]`;
    - else cnt++.
  - `PRESSED`: if `s=0` → `RELEASE_WAIT`, cnt←0.
  - `RELEASE_WAIT`:
    - if `s=1` → `PRESSED`, with no new pending;
    - else if cnt==`DEBOUNCE_CYCLES`-1 → `IDLE`;
    - else cnt++.
  - Only the `PRESS_WAIT`→`PRESSED` transition generates an event; releases never do.
- **Arbiter**, one register stage:
  - Each cycle, if `pending`≠0:
    - `o_enable` ← lowest-index set bit of `pending`, as one-hot;
    - that bit is cleared;
    - `o_switch` ← current synchronised switches.
  - Otherwise `o_enable` ← 0 and `o_switch` holds.
- **Simultaneous events**
  - Several buttons accepted in the same cycle are all kept pending and issued one per cycle, lowest index first.
  - A pending bit set on the same edge another is cleared is retained.
- **Reset**
  - Asynchronous active-low reset is honoured mid-operation: debounce progress and pending events are discarded immediately.
  - After reset, every FSM is in `IDLE` with cnt=0, `pending`=0, synchronisers at 0.
  - Reset values: `o_enable`=0, `o_switch`=0.
  - A button held through reset release is treated as a new press and pulses after the full debounce time.

## Timing
- Latency, taking edge 0 as the first edge that samples a pad high:
  - synchronised `s`=1 after edge 1;
  - `PRESS_WAIT` entered at edge 2;
  - `PRESSED` and pending at edge `DEBOUNCE_CYCLES`+2;
  - `o_enable` high for exactly one cycle after edge `DEBOUNCE_CYCLES`+3 when no other pending bit has priority.
- Each lower-index pending event ahead of a button delays its pulse by one cycle.
- `o_enable` is never multi-hot and never high for two consecutive cycles for the same button per press.
- `o_switch` changes only on the edge where `o_enable` becomes non-zero; it is valid and stable in that same cycle and remains so until the next pulse.
- Throughput: at most one pulse per cycle. Maximum press rate per button is one per 2×`DEBOUNCE_CYCLES`+O(1) cycles.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=8.
- **Clean press:** `i_switch`=4'b0101, `i_boton[0]` 0→1 at edge 0 and held → `o_enable`=4'b0001 for exactly the cycle after edge 11, `o_switch`=4'b0101 from that edge on, no further pulses while held or on release.
- **Bounce:**
  - `i_boton[1]` toggles 1,0,1,0 every 3 cycles, then stays 1 → single `o_enable`=4'b0010, 11 edges after the final rising sample.
  - Glitch of 1 cycle high → no pulse.
- **Simultaneous press:** `i_boton`=4'b0110 rises on one edge → `o_enable`=4'b0010 then 4'b0100 on consecutive cycles; `o_switch` captured at each pulse edge.
- **Release bounce:** after accepted press of `i_boton[2]`, release with 3-cycle re-press bounces → no extra pulse; a new clean press after ≥8 stable-low cycles → exactly one more pulse.
- **Reset mid-operation:**
  - `i_reset`=0 asserted asynchronously between clock edges during `PRESS_WAIT` (cnt=5) → `o_enable`=0 and `o_switch`=0 immediately, no pulse afterwards.
  - Button held through reset release → pulse 11 edges after the first edge sampling it post-reset.
- **ALU integration:** pulses on buttons 0, 1, 2 with switches 3, 2, 4'b0000 → ALU loads operand1=3, operand2=2, op=0 in order, one load each.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Pad-side and ALU-side buses of the input conditioner, bundled as one port.
// master: the board/bench side that drives pads and consumes the pulses.
// slave:  the conditioner itself.
interface input_conditioner_if #(
  parameter int CANT_SWITCHES = 4,
  parameter int CANT_BOTONES  = 4
);
  logic [CANT_SWITCHES-1:0] i_switch;
  logic [CANT_BOTONES-1:0]  i_boton;
  logic [CANT_BOTONES-1:0]  o_enable;
  logic [CANT_SWITCHES-1:0] o_switch;

  modport master (
    output i_switch,
    output i_boton,
    input  o_enable,
    input  o_switch
  );

  modport slave (
    input  i_switch,
    input  i_boton,
    output o_enable,
    output o_switch
  );
endinterface

// File: rtl/input_conditioner.sv
// Input conditioner: synchronises switch/button pads, debounces each button
// independently and turns every accepted press into a one-cycle, one-hot
// enable pulse together with a switch snapshot for the ALU.

// One button lane: 2-flop synchroniser plus debounce FSM. 'accept' is high
// for exactly the cycle in which the FSM moves PRESS_WAIT -> PRESSED, so the
// pending bit upstream is set on that same edge.
module input_conditioner_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK100MHZ,
  input  logic i_reset,
  input  logic boton,
  output logic accept
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic    [1:0]    sync;
  logic             s;
  state_t           state, state_n;
  logic    [CW-1:0] cnt, cnt_n;

  assign s = sync[1];

  // Two-flop synchroniser for the raw, asynchronous button pad.
  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) sync <= 2'b00;
    else          sync <= {sync[0], boton};
  end

  // Debounce state and counter registers.
  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic; the input must hold steady for DEBOUNCE_CYCLES cycles
  // in either direction before the FSM commits. A re-press during the release
  // wait drops straight back to PRESSED without raising a new event.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_n = PRESSED;
          accept  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_n = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end
endmodule

module input_conditioner #(
  parameter int CANT_SWITCHES   = 4,
  parameter int CANT_BOTONES    = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                CLK100MHZ,
  input  logic                i_reset,
  input_conditioner_if.slave  bus
);
  logic [CANT_SWITCHES-1:0] sw_meta, sw_sync;
  logic [CANT_BOTONES-1:0]  boton;
  logic [CANT_BOTONES-1:0]  accept;
  logic [CANT_BOTONES-1:0]  pending;
  logic [CANT_BOTONES-1:0]  grant;
  logic [CANT_BOTONES-1:0]  enable_q;
  logic [CANT_SWITCHES-1:0] switch_q;

  assign boton        = bus.i_boton;
  assign bus.o_enable = enable_q;
  assign bus.o_switch = switch_q;

  // Switches are level signals read only at pulse time: synchronise, no debounce.
  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= bus.i_switch;
      sw_sync <= sw_meta;
    end
  end

  // One independent debounce lane per button.
  for (genvar g = 0; g < CANT_BOTONES; g++) begin : g_lane
    input_conditioner_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_lane (
      .CLK100MHZ (CLK100MHZ),
      .i_reset   (i_reset),
      .boton     (boton[g]),
      .accept    (accept[g])
    );
  end

  // Lowest-index pending event wins; isolate it with the two's-complement trick.
  always_comb begin
    grant = pending & (~pending + CANT_BOTONES'(1));
  end

  // Arbiter stage: issue one event per cycle. New accepts are OR-ed in after
  // the grant is cleared so an event landing on the same edge is never lost.
  // The snapshot register only moves when a pulse is issued.
  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      pending  <= '0;
      enable_q <= '0;
      switch_q <= '0;
    end else begin
      pending  <= (pending & ~grant) | accept;
      enable_q <= grant;
      if (|pending) switch_q <= sw_sync;
    end
  end
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=8. Expected pulses
// (cycle, enable, switch snapshot) are queued when a press is driven; a
// monitor pops and compares every non-zero o_enable. Any pulse with an empty
// queue is reported as unexpected.
module tb_input_conditioner;
  localparam int DC = 8;

  typedef struct {
    int       cyc;
    logic [3:0] en;
    logic [3:0] sw;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  // Small ALU-side model: one register per load enable.
  logic [3:0] alu_op1 = 4'hF;
  logic [3:0] alu_op2 = 4'hF;
  logic [3:0] alu_op  = 4'hF;
  int         alu_loads = 0;

  input_conditioner_if #(.CANT_SWITCHES(4), .CANT_BOTONES(4)) bus ();

  input_conditioner #(
    .CANT_SWITCHES   (4),
    .CANT_BOTONES    (4),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .CLK100MHZ (clk),
    .i_reset   (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    case (bus.o_enable)
      4'b0001: begin alu_op1 <= bus.o_switch; alu_loads <= alu_loads + 1; end
      4'b0010: begin alu_op2 <= bus.o_switch; alu_loads <= alu_loads + 1; end
      4'b0100: begin alu_op  <= bus.o_switch; alu_loads <= alu_loads + 1; end
      default: ;
    endcase
  end

  // Scoreboard monitor: every pulse must match the head of the queue exactly.
  always @(negedge clk) begin
    if (bus.o_enable !== 4'b0000) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: o_enable=%b o_switch=%b at cyc %0d", bus.o_enable, bus.o_switch, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.o_enable !== e.en || bus.o_switch !== e.sw || cyc != e.cyc) begin
          n_err++;
          $display("FAIL pulse: got en=%b sw=%b cyc=%0d, want en=%b sw=%b cyc=%0d",
                   bus.o_enable, bus.o_switch, cyc, e.en, e.sw, e.cyc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    bus.i_switch = 4'b0000;
    bus.i_boton  = 4'b0000;
    rst_n = 1'b0;
    idle(3);
    n_cmp++;
    if (bus.o_enable !== 4'b0000) begin
      n_err++; $display("FAIL reset_enable: got %b want 0000", bus.o_enable);
    end
    n_cmp++;
    if (bus.o_switch !== 4'b0000) begin
      n_err++; $display("FAIL reset_switch: got %b want 0000", bus.o_switch);
    end
    rst_n = 1'b1;
    idle(3);
    n_cmp++;
    if (bus.o_enable !== 4'b0000) begin
      n_err++; $display("FAIL idle_enable: got %b want 0000", bus.o_enable);
    end
  endtask

  task automatic test_clean_press;
    bus.i_switch = 4'b0101;
    idle(4);
    sb.push_back('{cyc + DC + 4, 4'b0001, 4'b0101});
    bus.i_boton = 4'b0001;
    idle(30);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL clean_missing: %0d pulses outstanding, want 0", sb.size()); sb.delete();
    end
    bus.i_boton = 4'b0000;
    idle(20);
    n_cmp++;
    if (bus.o_switch !== 4'b0101) begin
      n_err++; $display("FAIL clean_hold_switch: got %b want 0101", bus.o_switch);
    end
  endtask

  task automatic test_bounce;
    bus.i_switch = 4'b1100;
    idle(4);
    for (int k = 0; k < 4; k++) begin
      bus.i_boton = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      idle(3);
    end
    sb.push_back('{cyc + DC + 4, 4'b0010, 4'b1100});
    bus.i_boton = 4'b0010;
    idle(30);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL bounce_missing: %0d pulses outstanding, want 0", sb.size()); sb.delete();
    end
    bus.i_boton = 4'b0000;
    idle(20);
    // single-cycle glitch must be rejected
    bus.i_boton = 4'b0010;
    idle(1);
    bus.i_boton = 4'b0000;
    idle(20);
    n_cmp++;
    if (bus.o_switch !== 4'b1100) begin
      n_err++; $display("FAIL glitch_switch: got %b want 1100", bus.o_switch);
    end
  endtask

  task automatic test_simultaneous;
    bus.i_switch = 4'b1010;
    idle(4);
    sb.push_back('{cyc + DC + 4, 4'b0010, 4'b1010});
    sb.push_back('{cyc + DC + 5, 4'b0100, 4'b1010});
    bus.i_boton = 4'b0110;
    idle(30);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL simul_missing: %0d pulses outstanding, want 0", sb.size()); sb.delete();
    end
    bus.i_boton = 4'b0000;
    idle(20);
  endtask

  task automatic test_release_bounce;
    bus.i_switch = 4'b0011;
    idle(4);
    sb.push_back('{cyc + DC + 4, 4'b0100, 4'b0011});
    bus.i_boton = 4'b0100;
    idle(20);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL relb_first_missing: %0d outstanding, want 0", sb.size()); sb.delete();
    end
    for (int k = 0; k < 4; k++) begin
      bus.i_boton = (k % 2 == 0) ? 4'b0000 : 4'b0100;
      idle(3);
    end
    bus.i_boton = 4'b0000;
    idle(25);
    bus.i_switch = 4'b0110;
    idle(4);
    sb.push_back('{cyc + DC + 4, 4'b0100, 4'b0110});
    bus.i_boton = 4'b0100;
    idle(20);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL relb_second_missing: %0d outstanding, want 0", sb.size()); sb.delete();
    end
    bus.i_boton = 4'b0000;
    idle(20);
  endtask

  task automatic test_reset_mid;
    bus.i_switch = 4'b1111;
    idle(4);
    bus.i_boton = 4'b0001;
    // cnt reaches 5 after the 8th edge following the drive
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.o_enable !== 4'b0000) begin
      n_err++; $display("FAIL midreset_enable: got %b want 0000", bus.o_enable);
    end
    n_cmp++;
    if (bus.o_switch !== 4'b0000) begin
      n_err++; $display("FAIL midreset_switch: got %b want 0000", bus.o_switch);
    end
    @(negedge clk);
    bus.i_boton = 4'b0000;
    idle(3);
    rst_n = 1'b1;
    idle(20);
    n_cmp++;
    if (bus.o_switch !== 4'b0000) begin
      n_err++; $display("FAIL midreset_no_pulse: o_switch got %b want 0000", bus.o_switch);
    end
    // button held through reset release
    bus.i_boton = 4'b0010;
    rst_n = 1'b0;
    idle(2);
    sb.push_back('{cyc + DC + 4, 4'b0010, 4'b1111});
    rst_n = 1'b1;
    idle(30);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL held_reset_missing: %0d outstanding, want 0", sb.size()); sb.delete();
    end
    bus.i_boton = 4'b0000;
    idle(20);
  endtask

  task automatic test_alu;
    int base;
    logic [3:0] sws [3];
    sws[0] = 4'd3; sws[1] = 4'd2; sws[2] = 4'b0000;
    base = alu_loads;
    for (int b = 0; b < 3; b++) begin
      bus.i_switch = sws[b];
      idle(4);
      sb.push_back('{cyc + DC + 4, 4'(1 << b), sws[b]});
      bus.i_boton = 4'(1 << b);
      idle(20);
      bus.i_boton = 4'b0000;
      idle(20);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL alu_missing: %0d outstanding, want 0", sb.size()); sb.delete();
    end
    n_cmp++;
    if (alu_op1 !== 4'd3) begin
      n_err++; $display("FAIL alu_op1: got %0d want 3", alu_op1);
    end
    n_cmp++;
    if (alu_op2 !== 4'd2) begin
      n_err++; $display("FAIL alu_op2: got %0d want 2", alu_op2);
    end
    n_cmp++;
    if (alu_op !== 4'd0) begin
      n_err++; $display("FAIL alu_op: got %0d want 0", alu_op);
    end
    n_cmp++;
    if (alu_loads - base != 3) begin
      n_err++; $display("FAIL alu_loads: got %0d want 3", alu_loads - base);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_release_bounce();
    test_reset_mid();
    test_alu();
    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
